// File: rtl/mest_pro_fetch_rs.sv
// rtl/mest_pro_fetch_rs.sv - instruction fetch unit with program counter and return stack
module mest_pro_fetch_rs #(
  parameter int ADDR_BITS        = 10,
  parameter int INSTRUCTION_SIZE = 16,
  parameter int CONST_K_SIZE     = 10,
  parameter int RS_DEPTH         = 4
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic                        idle_state,
  input  logic                        fetch_state,
  input  logic                        exec_state,
  input  logic                        jump,
  input  logic                        call,
  input  logic                        return_pc,
  input  logic [CONST_K_SIZE-1:0]     const_K,
  output logic [INSTRUCTION_SIZE-1:0] decode_reg,
  output logic                        o_fetch_done,
  output logic                        o_rs_ovf,
  output logic                        o_rs_unf,
  output logic                        o_req,
  output logic [ADDR_BITS-1:0]        o_prog_counter,
  input  logic                        i_ack,
  input  logic [INSTRUCTION_SIZE-1:0] i_instruction
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_BITS-1:0]        pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0] decode_q, decode_d;
  logic [SP_W-1:0]             sp_q, sp_d;
  logic                        fetched_q, fetched_d;
  logic                        fetch_done_q, fetch_done_d;
  logic                        ovf_q, ovf_d;
  logic                        unf_q, unf_d;
  logic [ADDR_BITS-1:0]        stack_q [RS_DEPTH];
  logic                        push_en;
  logic [ADDR_BITS-1:0]        k_addr;
  logic [IDX_W-1:0]            top_idx;
  logic                        take;
  logic                        rs_full;
  logic                        rs_empty;

  // Jump/call target resized to the address width (zero-extend or truncate).
  if (CONST_K_SIZE >= ADDR_BITS) begin : g_k_trunc
    assign k_addr = const_K[ADDR_BITS-1:0];
  end else begin : g_k_ext
    assign k_addr = {{(ADDR_BITS-CONST_K_SIZE){1'b0}}, const_K};
  end

  // Request is held off during reset so no fetch escapes while the core is held.
  assign o_req          = fetch_state & ~fetched_q & ~idle_state & i_reset_n;
  assign take           = o_req & i_ack;
  assign top_idx        = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign rs_full        = (sp_q == SP_W'(RS_DEPTH));
  assign rs_empty       = (sp_q == '0);
  assign decode_reg     = decode_q;
  assign o_fetch_done   = fetch_done_q;
  assign o_rs_ovf       = ovf_q;
  assign o_rs_unf       = unf_q;
  assign o_prog_counter = pc_q;

  // Next-state: idle clears everything, fetch handles the memory handshake, exec does flow control.
  always_comb begin
    pc_d         = pc_q;
    decode_d     = decode_q;
    sp_d         = sp_q;
    fetched_d    = fetched_q;
    fetch_done_d = take;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    push_en      = 1'b0;
    if (idle_state) begin
      pc_d         = '0;
      decode_d     = '0;
      sp_d         = '0;
      fetched_d    = 1'b0;
      fetch_done_d = 1'b0;
      ovf_d        = 1'b0;
      unf_d        = 1'b0;
    end else if (fetch_state) begin
      if (take) begin
        decode_d  = i_instruction;
        pc_d      = pc_q + ADDR_BITS'(1);
        fetched_d = 1'b1;
      end
    end else begin
      fetched_d = 1'b0;
      if (exec_state) begin
        if (jump) begin
          pc_d = k_addr;
        end else if (call) begin
          pc_d = k_addr;
          if (rs_full) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end
        end else if (return_pc) begin
          if (rs_empty) begin
            unf_d = 1'b1;
          end else begin
            pc_d = stack_q[top_idx];
            sp_d = sp_q - SP_W'(1);
          end
        end
      end
    end
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q         <= '0;
      decode_q     <= '0;
      sp_q         <= '0;
      fetched_q    <= 1'b0;
      fetch_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      decode_q     <= decode_d;
      sp_q         <= sp_d;
      fetched_q    <= fetched_d;
      fetch_done_q <= fetch_done_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // Return-stack storage; contents are unreachable once sp is cleared, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[sp_q[IDX_W-1:0]] <= pc_q;
    end
  end

endmodule
